// File: rtl/pipe_pkg.sv
// Shared types and constants for the register scoreboard and the control
// logic that drives its producer-latency input.
package pipe_pkg;

  localparam int NREG_DEF    = 32;
  localparam int AW_DEF      = $clog2(NREG_DEF);
  localparam int MAX_LAT_DEF = 15;
  localparam int LAT_W_DEF   = $clog2(MAX_LAT_DEF + 1);

  // Producer latencies used by Control when driving issue_lat_i
  localparam int LAT_ALU  = 1;
  localparam int LAT_LOAD = 2;

  typedef logic [AW_DEF-1:0]    reg_addr_t;
  typedef logic [LAT_W_DEF-1:0] lat_t;

  typedef enum logic {
    FWD_NONE = 1'b0,
    FWD_FULL = 1'b1
  } fwd_mode_e;

endpackage

// File: rtl/pipe_scoreboard_sb_counter.sv
// Per-register countdown of cycles until the pending result is available.
// A load always wins over the decrement in the same cycle.
module sb_counter
  import pipe_pkg::*;
#(
  parameter int W = LAT_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         nz_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_o <= '0;
    end else if (load_i) begin
      cnt_o <= load_val_i;
    end else if (cnt_o != '0) begin
      cnt_o <= cnt_o - W'(1);
    end
  end

  assign nz_o = (cnt_o != '0);

endmodule

// File: rtl/pipe_scoreboard.sv
// ID-stage register scoreboard: per-register latency countdowns drive the
// RAW/WAW stall, the issue accept and a saturating stall-cycle counter.
module pipe_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int AW        = $clog2(NREG),
  parameter int MAX_LAT   = 15,
  parameter int FWD       = 1,
  parameter int WAW_STALL = 1,
  parameter int PERF_W    = 16,
  localparam int LAT_W    = $clog2(MAX_LAT + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              issue_valid_i,
  input  logic [AW-1:0]     issue_rs_i,
  input  logic [AW-1:0]     issue_rt_i,
  input  logic              issue_use_rs_i,
  input  logic              issue_use_rt_i,
  input  logic              issue_wr_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic [LAT_W-1:0]  issue_lat_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              accept_o,
  output logic [NREG-1:0]   busy_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  localparam fwd_mode_e FWD_MODE = (FWD != 0) ? FWD_FULL : FWD_NONE;

  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] lat_eff;
  logic [LAT_W-1:0] rs_cnt, rt_cnt, rd_cnt;
  logic             rs_blk, rt_blk, raw, waw;

  // With forwarding the consumer can issue in the producer's final cycle
  function automatic logic blocked(input logic [LAT_W-1:0] c);
    if (FWD_MODE == FWD_FULL) return (c > LAT_W'(1));
    else                      return (c != '0);
  endfunction

  always_comb begin
    lat_eff  = (issue_lat_i > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat_i;
    rs_cnt   = cnt[issue_rs_i];
    rt_cnt   = cnt[issue_rt_i];
    rd_cnt   = cnt[issue_rd_i];
    rs_blk   = (issue_rs_i != '0) && blocked(rs_cnt);
    rt_blk   = (issue_rt_i != '0) && blocked(rt_cnt);
    raw      = issue_valid_i && ((issue_use_rs_i && rs_blk) || (issue_use_rt_i && rt_blk));
    waw      = (WAW_STALL != 0) && issue_valid_i && issue_wr_i &&
               (issue_rd_i != '0) && (rd_cnt > lat_eff);
    stall_o  = (raw || waw) && !flush_i;
    accept_o = issue_valid_i && !stall_o && !flush_i;
  end

  assign cnt[0]    = '0;
  assign busy_o[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.W(LAT_W)) u_cnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .load_i     (accept_o && issue_wr_i && (issue_rd_i == AW'(r))),
      .load_val_i (lat_eff),
      .cnt_o      (cnt[r]),
      .nz_o       (busy_o[r])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + PERF_W'(1);
    end
  end

endmodule
